m16_pattern_filler: RTL and testbench

M16_PATTERN_FILLER -- requirements
Module: m16_pattern_filler

---
 rtl/m16_pattern_filler.sv | 137 +++++++++++++
 tb/tb_m16_pattern_filler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/m16_pattern_filler.sv
// ============================================================================
// Module  : m16_pattern_filler
// Brief   : Per-request frame word generator with table, ramp, walking-one,
//           marker and slot-counter payload sources.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module m16_pattern_filler #(
  parameter int WORD_W     = 12,
  parameter int DATA_W     = 8,
  parameter int PTR_W      = 11,
  parameter int SLOT_BITS  = 5,
  parameter int UP_SLOT    = 0,
  parameter int DOWN_SLOT  = 11,
  parameter int MARKER_PTR = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 get_word,
  input  logic [PTR_W-1:0]     rd_ptr,
  input  logic [1:0]           mode,
  input  logic                 cfg_we,
  input  logic [SLOT_BITS-1:0] cfg_addr,
  input  logic [DATA_W-1:0]    cfg_data,
  output logic [WORD_W-1:0]    data_word,
  output logic                 word_valid
);

  localparam int          c_PAD_W  = WORD_W - 1 - DATA_W;
  localparam int          c_SLOTS  = 1 << SLOT_BITS;
  localparam int          c_BIT_W  = $clog2(DATA_W);
  localparam logic [1:0]  c_MODE_TABLE  = 2'd0;
  localparam logic [1:0]  c_MODE_RAMP   = 2'd1;
  localparam logic [1:0]  c_MODE_WALK   = 2'd2;
  localparam logic [1:0]  c_MODE_MARKER = 2'd3;
  localparam logic [WORD_W-1:0] c_MARKER_WORD = WORD_W'(2);

  logic [DATA_W-1:0] r_table [c_SLOTS];
  logic [DATA_W-1:0] r_up_cnt;
  logic [DATA_W-1:0] r_down_cnt;
  logic              r_up_arm;
  logic              r_down_arm;
  logic [PTR_W-1:0]  r_prev_ptr;

  logic [SLOT_BITS-1:0] w_slot;
  logic                 w_ptr_changed;
  logic                 w_up_arm_eff;
  logic                 w_down_arm_eff;
  logic                 w_is_marker;
  logic                 w_up_hit;
  logic                 w_down_hit;
  logic                 w_half_start;
  logic                 w_up_upd;
  logic                 w_down_upd;
  logic [DATA_W-1:0]    w_slot_payload;
  logic [DATA_W-1:0]    w_walk;
  logic [DATA_W-1:0]    w_payload;
  logic [WORD_W-1:0]    w_word;

  assign w_slot        = rd_ptr[SLOT_BITS-1:0];
  assign w_ptr_changed = (rd_ptr != r_prev_ptr);
  // A fresh pointer re-arms both counters within the same request.
  assign w_up_arm_eff   = r_up_arm   | w_ptr_changed;
  assign w_down_arm_eff = r_down_arm | w_ptr_changed;

  assign w_is_marker  = (mode == c_MODE_MARKER) || (rd_ptr == PTR_W'(MARKER_PTR));
  assign w_up_hit     = (mode == c_MODE_TABLE) && (w_slot == SLOT_BITS'(UP_SLOT));
  assign w_down_hit   = (mode == c_MODE_TABLE) && (w_slot == SLOT_BITS'(DOWN_SLOT));
  assign w_half_start = (rd_ptr[PTR_W-2:0] == '0);
  assign w_up_upd     = get_word && w_up_hit && w_half_start && w_up_arm_eff;
  assign w_down_upd   = get_word && w_down_hit && w_down_arm_eff;

  assign w_walk = DATA_W'(1) << rd_ptr[c_BIT_W-1:0];

  always_comb begin
    w_slot_payload = r_table[w_slot];
    if (w_up_hit) begin
      w_slot_payload = r_up_cnt;
    end else if (w_down_hit) begin
      w_slot_payload = r_down_cnt;
    end
  end

  always_comb begin
    w_payload = w_slot_payload;
    if (mode == c_MODE_RAMP) begin
      w_payload = rd_ptr[DATA_W-1:0];
    end else if (mode == c_MODE_WALK) begin
      w_payload = w_walk;
    end
  end

  always_comb begin
    w_word = {1'b0, w_payload, {c_PAD_W{1'b0}}};
    if (w_is_marker) begin
      w_word = c_MARKER_WORD;
    end
  end

  // Table read above sees the pre-write entry, so a coincident cfg write
  // only becomes visible to the following request.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_word  <= '0;
      word_valid <= 1'b0;
      r_up_cnt   <= '0;
      r_down_cnt <= '0;
      r_up_arm   <= 1'b1;
      r_down_arm <= 1'b1;
      r_prev_ptr <= '1;
      for (int i = 0; i < c_SLOTS; i++) begin
        r_table[i] <= DATA_W'(100 + i);
      end
    end else begin
      word_valid <= get_word;
      if (get_word) begin
        data_word  <= w_word;
        r_prev_ptr <= rd_ptr;
        r_up_arm   <= w_up_upd   ? 1'b0 : w_up_arm_eff;
        r_down_arm <= w_down_upd ? 1'b0 : w_down_arm_eff;
        if (w_up_upd) begin
          r_up_cnt <= r_up_cnt + 1'b1;
        end
        if (w_down_upd) begin
          r_down_cnt <= r_down_cnt - 1'b1;
        end
      end
      if (cfg_we) begin
        r_table[cfg_addr] <= cfg_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_m16_pattern_filler.sv
// ============================================================================
// Module  : tb_m16_pattern_filler
// Brief   : Directed vector table plus randomized run against a reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_m16_pattern_filler;

  logic        clk = 1'b0;
  logic        reset;
  logic        get_word;
  logic [10:0] rd_ptr;
  logic [1:0]  mode;
  logic        cfg_we;
  logic [4:0]  cfg_addr;
  logic [7:0]  cfg_data;
  logic [11:0] data_word;
  logic        word_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  m16_pattern_filler dut (
    .clk        (clk),
    .reset      (reset),
    .get_word   (get_word),
    .rd_ptr     (rd_ptr),
    .mode       (mode),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .data_word  (data_word),
    .word_valid (word_valid)
  );

  // Reference model state
  int          m_up, m_down, m_prev;
  bit          m_up_arm, m_down_arm;
  int          m_tbl [32];
  logic [11:0] m_word;
  bit          m_valid;

  task automatic model_step(input bit rst, input bit gw, input int ptr, input int md,
                            input bit we, input int addr, input int dat);
    int slot;
    int p;
    if (rst) begin
      m_word = '0; m_valid = 0; m_up = 0; m_down = 0;
      m_up_arm = 1; m_down_arm = 1; m_prev = 2047;
      for (int i = 0; i < 32; i++) m_tbl[i] = (100 + i) % 256;
    end else begin
      if (gw) begin
        slot = ptr % 32;
        if (ptr != m_prev) begin
          m_up_arm = 1; m_down_arm = 1;
        end
        if (md == 1) p = ptr % 256;
        else if (md == 2) p = 1 << (ptr % 8);
        else if (slot == 0) p = m_up;
        else if (slot == 11) p = m_down;
        else p = m_tbl[slot];
        if (md == 3 || ptr == 16) m_word = 12'h002;
        else m_word = 12'(p * 8);
        if (md == 0 && slot == 0 && (ptr % 1024) == 0 && m_up_arm) begin
          m_up = (m_up + 1) % 256; m_up_arm = 0;
        end
        if (md == 0 && slot == 11 && m_down_arm) begin
          m_down = (m_down + 255) % 256; m_down_arm = 0;
        end
        m_prev  = ptr;
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      if (we) m_tbl[addr] = dat;
    end
  endtask

  task automatic cycle(input bit rst, input bit gw, input logic [10:0] ptr, input logic [1:0] md,
                       input bit we, input logic [4:0] addr, input logic [7:0] dat);
    reset = rst; get_word = gw; rd_ptr = ptr; mode = md;
    cfg_we = we; cfg_addr = addr; cfg_data = dat;
    model_step(rst, gw, int'(ptr), int'(md), we, int'(addr), int'(dat));
    @(posedge clk); #1;
    checks++;
    if (data_word !== m_word || word_valid !== m_valid) begin
      failures++;
      $display("FAIL model ptr=%0d mode=%0d: got word=%h valid=%b, expected word=%h valid=%b",
               ptr, md, data_word, word_valid, m_word, m_valid);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          gw;
    logic [10:0] ptr;
    logic [1:0]  md;
    bit          we;
    logic [4:0]  addr;
    logic [7:0]  dat;
    logic [11:0] exp_word;
    bit          exp_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input bit rst, input bit gw, input logic [10:0] ptr, input logic [1:0] md,
                   input bit we, input logic [4:0] addr, input logic [7:0] dat,
                   input logic [11:0] ew, input bit ev);
    vec_t t;
    t.rst = rst; t.gw = gw; t.ptr = ptr; t.md = md; t.we = we;
    t.addr = addr; t.dat = dat; t.exp_word = ew; t.exp_valid = ev;
    vecs.push_back(t);
  endtask

  int hot [6] = '{0, 1024, 11, 43, 16, 32};

  initial begin
    logic [10:0] last_ptr;
    logic [10:0] p;
    logic [1:0]  md;

    reset = 1; get_word = 0; rd_ptr = '0; mode = '0;
    cfg_we = 0; cfg_addr = '0; cfg_data = '0;

    // Up counter: frame start / half frame, repeated pointer does not re-update
    v(1, 0, 0,     0, 0, 0, 0, 12'h000, 0);
    v(0, 1, 0,     0, 0, 0, 0, 12'h000, 1);
    v(0, 1, 0,     0, 0, 0, 0, 12'h008, 1);
    v(0, 1, 1024,  0, 0, 0, 0, 12'h008, 1);
    v(0, 1, 32,    0, 0, 0, 0, 12'h010, 1);
    // Down counter wrap, repeat hold, re-arm
    v(1, 0, 0,     0, 0, 0, 0, 12'h000, 0);
    v(0, 1, 11,    0, 0, 0, 0, 12'h000, 1);
    v(0, 1, 11,    0, 0, 0, 0, 12'h7F8, 1);
    v(0, 1, 43,    0, 0, 0, 0, 12'h7F8, 1);
    v(0, 1, 75,    0, 0, 0, 0, 12'h7F0, 1);
    // Table read-before-write, reset beats cfg write
    v(1, 0, 0,     0, 0, 0, 0, 12'h000, 0);
    v(0, 1, 3,     0, 0, 0, 0, 12'h338, 1);
    v(0, 1, 35,    0, 1, 3, 8'hAA, 12'h338, 1);
    v(0, 1, 67,    0, 0, 0, 0, 12'h550, 1);
    v(1, 1, 67,    0, 1, 3, 8'h55, 12'h000, 0);
    v(0, 1, 3,     0, 0, 0, 0, 12'h338, 1);
    // Marker, ramp, walking-one
    v(0, 1, 16,    0, 0, 0, 0, 12'h002, 1);
    v(0, 1, 5,     3, 0, 0, 0, 12'h002, 1);
    v(0, 1, 11'h1F5, 1, 0, 0, 0, 12'h7A8, 1);
    v(0, 1, 3,     2, 0, 0, 0, 12'h040, 1);
    for (int i = 0; i < 10; i++) v(0, 0, 11'h7FF, 1, 0, 0, 0, 12'h040, 0);
    v(1, 1, 11'h1F5, 1, 0, 0, 0, 12'h000, 0);
    v(0, 0, 0,     0, 0, 0, 0, 12'h000, 0);

    foreach (vecs[k]) begin
      cycle(vecs[k].rst, vecs[k].gw, vecs[k].ptr, vecs[k].md,
            vecs[k].we, vecs[k].addr, vecs[k].dat);
      checks++;
      if (data_word !== vecs[k].exp_word || word_valid !== vecs[k].exp_valid) begin
        failures++;
        $display("FAIL vec%0d: got word=%h valid=%b, expected word=%h valid=%b",
                 k, data_word, word_valid, vecs[k].exp_word, vecs[k].exp_valid);
      end
    end

    cycle(1, 0, 0, 0, 0, 0, 0);
    last_ptr = '0;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 5))
        0:       p = last_ptr;
        1, 2:    p = 11'(hot[$urandom_range(0, 5)]);
        default: p = 11'($urandom_range(0, 2047));
      endcase
      md = ($urandom_range(0, 1) == 1) ? 2'd0 : 2'($urandom_range(0, 3));
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7), p, md,
            ($urandom_range(0, 4) == 0), 5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
      last_ptr = p;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
